// File: rtl/arbiter_types.sv
// Shared types for the L1-to-memory cacheline arbiter.
// Requester identities and arbiter FSM states.
package arbiter_types;

    localparam int LINE_W_DEF = 256;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } requester_t;

endpackage

// File: rtl/rr_picker.sv
// Two-way grant selection: round-robin on ties, or fixed dcache priority.
module rr_picker
    import arbiter_types::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       req_i,
    input  logic       req_d,
    input  requester_t last,
    output logic       valid,
    output requester_t grant
);

    always_comb begin
        valid = req_i | req_d;
        grant = ICACHE;
        if (req_i && req_d) begin
            if (RR_EN == 0) begin
                grant = DCACHE;
            end else begin
                grant = (last == ICACHE) ? DCACHE : ICACHE;
            end
        end else if (req_d) begin
            grant = DCACHE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes icache/dcache line transactions onto one memory port.
// Winner's command is latched at grant; response routed to winner only.
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        state;
    arb_state_t        state_nx;
    requester_t        last_grant;
    requester_t        grant;
    logic              grant_valid;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;

    rr_picker #(
        .RR_EN(RR_EN)
    ) u_picker (
        .req_i(i_read),
        .req_d(d_read | d_write),
        .last (last_grant),
        .valid(grant_valid),
        .grant(grant)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nx = (grant == DCACHE) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: if (mem_resp) state_nx = RESP_I;
            SERVE_D: if (mem_resp) state_nx = RESP_D;
            RESP_I:  state_nx = IDLE;
            RESP_D:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A read+write collision from dcache is latched as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ICACHE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && grant_valid) begin
                last_grant <= grant;
                if (grant == DCACHE) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    write_q <= d_write;
                end else begin
                    addr_q  <= i_addr;
                    write_q <= 1'b0;
                end
            end
            if (state == SERVE_I && mem_resp) begin
                i_rdata_q <= mem_rdata;
            end
            if (state == SERVE_D && mem_resp) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_read  = (state == SERVE_I) || (state == SERVE_D && !write_q);
    assign mem_write = (state == SERVE_D) && write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_resp    = (state == RESP_I);
    assign d_resp    = (state == RESP_D);
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(d_read && d_write))
            else $error("dcache drove read and write together");
            assert (!mem_resp || state == SERVE_I || state == SERVE_D)
            else $error("mem_resp with no transaction outstanding");
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 round-robin, instance 1 fixed priority.
// A transaction-level model predicts winner, command and returned lines.
module tb_mem_arbiter;
    import arbiter_types::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n     [2];
    logic          i_read    [2];
    logic [AW-1:0] i_addr    [2];
    logic [LW-1:0] i_rdata   [2];
    logic          i_resp    [2];
    logic          d_read    [2];
    logic          d_write   [2];
    logic [AW-1:0] d_addr    [2];
    logic [LW-1:0] d_wdata   [2];
    logic [LW-1:0] d_rdata   [2];
    logic          d_resp    [2];
    logic          mem_read  [2];
    logic          mem_write [2];
    logic [AW-1:0] mem_addr  [2];
    logic [LW-1:0] mem_wdata [2];
    logic [LW-1:0] mem_rdata [2];
    logic          mem_resp  [2];

    int passes = 0;
    int total  = 0;

    // model: pending requests, last served requester, last line per cache
    bit            pend_i [2];
    bit            pend_d [2];
    bit            m_dwr  [2];
    bit            last_d [2];
    logic [AW-1:0] m_iaddr[2];
    logic [AW-1:0] m_daddr[2];
    logic [LW-1:0] m_dwdat[2];
    logic [LW-1:0] m_irdat[2];
    logic [LW-1:0] m_drdat[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .LINE_W(LW),
            .ADDR_W(AW),
            .RR_EN (g == 0 ? 1 : 0)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .i_read   (i_read[g]),
            .i_addr   (i_addr[g]),
            .i_rdata  (i_rdata[g]),
            .i_resp   (i_resp[g]),
            .d_read   (d_read[g]),
            .d_write  (d_write[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_rdata  (d_rdata[g]),
            .d_resp   (d_resp[g]),
            .mem_read (mem_read[g]),
            .mem_write(mem_write[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .mem_resp (mem_resp[g])
        );
    end

    task automatic chk(input string tag, input logic [LW-1:0] obs,
                       input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h, required %h", tag, obs, exp);
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Next requester served: sole requester, else the one not served
    // last (round-robin) or dcache (fixed priority).
    function automatic bit next_is_d(input int k);
        if (pend_i[k] && pend_d[k]) return (k == 1) ? 1'b1 : !last_d[k];
        return pend_d[k];
    endfunction

    task automatic post_i(input int k, input logic [AW-1:0] a);
        pend_i[k]  = 1'b1;
        m_iaddr[k] = a;
        i_read[k]  = 1'b1;
        i_addr[k]  = a;
    endtask

    task automatic post_d(input int k, input bit wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] wd);
        pend_d[k]  = 1'b1;
        m_dwr[k]   = wr;
        m_daddr[k] = a;
        m_dwdat[k] = wd;
        d_read[k]  = !wr;
        d_write[k] = wr;
        d_addr[k]  = a;
        d_wdata[k] = wd;
    endtask

    task automatic check_zero(input int k, input string tag);
        chk({tag, "_mem_read"}, mem_read[k], 0);
        chk({tag, "_mem_write"}, mem_write[k], 0);
        chk({tag, "_mem_addr"}, mem_addr[k], 0);
        chk({tag, "_mem_wdata"}, mem_wdata[k], 0);
        chk({tag, "_i_resp"}, i_resp[k], 0);
        chk({tag, "_d_resp"}, d_resp[k], 0);
        chk({tag, "_i_rdata"}, i_rdata[k], 0);
        chk({tag, "_d_rdata"}, d_rdata[k], 0);
    endtask

    task automatic model_reset(input int k);
        pend_i[k]  = 0;
        pend_d[k]  = 0;
        last_d[k]  = 0;
        m_irdat[k] = '0;
        m_drdat[k] = '0;
        i_read[k]  = 0;
        d_read[k]  = 0;
        d_write[k] = 0;
        mem_resp[k] = 0;
    endtask

    // Called at an idle negedge with requests already posted.
    task automatic serve_next(input int k, input int lat, input logic [LW-1:0] rd);
        bit            d   = next_is_d(k);
        bit            ewr = d && m_dwr[k];
        logic [AW-1:0] ea  = d ? m_daddr[k] : m_iaddr[k];
        int            w   = 0;
        @(negedge clk);
        while (!mem_read[k] && !mem_write[k] && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_latency", w, 0);
        chk("mem_read", mem_read[k], !ewr);
        chk("mem_write", mem_write[k], ewr);
        chk("mem_addr", mem_addr[k], ea);
        if (ewr) chk("mem_wdata", mem_wdata[k], m_dwdat[k]);
        for (int j = 0; j < lat; j++) begin
            if (d) begin
                d_addr[k]  = $urandom;
                d_wdata[k] = rnd_line();
            end else begin
                i_addr[k] = $urandom;
            end
            mem_rdata[k] = rnd_line();
            @(negedge clk);
            chk("hold_addr", mem_addr[k], ea);
            chk("hold_cmd", {mem_read[k], mem_write[k]}, {!ewr, ewr});
            if (ewr) chk("hold_wdata", mem_wdata[k], m_dwdat[k]);
            chk("early_resp", {i_resp[k], d_resp[k]}, 0);
        end
        mem_resp[k]  = 1'b1;
        mem_rdata[k] = rd;
        @(negedge clk);
        mem_resp[k]  = 1'b0;
        mem_rdata[k] = rnd_line();
        last_d[k] = d;
        if (d) begin
            m_drdat[k] = rd;
            pend_d[k]  = 0;
            d_read[k]  = 0;
            d_write[k] = 0;
        end else begin
            m_irdat[k] = rd;
            pend_i[k]  = 0;
            i_read[k]  = 0;
        end
        chk("cmd_drop", {mem_read[k], mem_write[k]}, 0);
        chk("i_resp", i_resp[k], !d);
        chk("d_resp", d_resp[k], d);
        chk("i_rdata", i_rdata[k], m_irdat[k]);
        chk("d_rdata", d_rdata[k], m_drdat[k]);
        @(negedge clk);
        chk("resp_once", {i_resp[k], d_resp[k]}, 0);
        chk("idle_cmd", {mem_read[k], mem_write[k]}, 0);
        chk("i_rdata_hold", i_rdata[k], m_irdat[k]);
        chk("d_rdata_hold", d_rdata[k], m_drdat[k]);
    endtask

    task automatic random_rounds(input int k, input int n);
        for (int r = 0; r < n; r++) begin
            if (!pend_i[k] && !pend_d[k]) repeat ($urandom_range(2, 0)) @(negedge clk);
            if (!pend_i[k] && $urandom_range(1, 0) == 1) post_i(k, $urandom);
            if (!pend_d[k] && ($urandom_range(1, 0) == 1 || !pend_i[k]))
                post_d(k, $urandom_range(1, 0) == 1, $urandom, rnd_line());
            serve_next(k, $urandom_range(4, 0), rnd_line());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] pat_a;
        logic [LW-1:0] pat_b;
        pat_a = {8{32'hA5A5_0001}};
        pat_b = {8{32'hB00B_CAFE}};
        for (int k = 0; k < 2; k++) begin
            rst_n[k]     = 0;
            i_addr[k]    = '0;
            d_addr[k]    = '0;
            d_wdata[k]   = '0;
            mem_rdata[k] = '0;
            model_reset(k);
        end
        repeat (3) @(negedge clk);
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        rst_n[0] = 1;
        rst_n[1] = 1;
        @(negedge clk);

        // round-robin: tie out of reset goes to dcache, then icache
        post_i(0, 32'h0000_0080);
        post_d(0, 1'b0, 32'h0000_0200, '0);
        serve_next(0, 2, rnd_line());
        chk("rr_first_is_d", last_d[0], 1);
        serve_next(0, 3, rnd_line());
        post_i(0, 32'h0000_0060);
        serve_next(0, 5, pat_a);
        chk("i_alone_rdata", i_rdata[0], pat_a);
        post_d(0, 1'b1, 32'h0000_1000, pat_b);
        serve_next(0, 4, rnd_line());
        // last served was dcache, so this tie goes to icache
        post_i(0, 32'h0000_0040);
        post_d(0, 1'b0, 32'h0000_3000, '0);
        serve_next(0, 1, rnd_line());
        chk("rr_second_is_i", last_d[0], 0);
        serve_next(0, 0, rnd_line());

        // reset while icache waits on memory
        post_i(0, 32'h0000_0500);
        @(negedge clk);
        chk("pre_rst_read", mem_read[0], 1);
        @(negedge clk);
        rst_n[0] = 0;
        model_reset(0);
        #1;
        check_zero(0, "mid_rst");
        @(negedge clk);
        rst_n[0] = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_i_resp", i_resp[0], 0);
            chk("post_rst_cmd", {mem_read[0], mem_write[0]}, 0);
        end
        post_i(0, 32'h0000_0700);
        serve_next(0, 2, rnd_line());
        random_rounds(0, 30);

        // fixed priority: dcache wins every tie while it keeps requesting
        post_i(1, 32'h0000_0900);
        for (int t = 0; t < 4; t++) begin
            post_d(1, t[0], 32'h0000_2000 + 32'(t * 64), rnd_line());
            serve_next(1, $urandom_range(3, 0), rnd_line());
            chk("fixed_prio_d", last_d[1], 1);
            chk("i_still_waiting", pend_i[1] && i_read[1], 1);
        end
        serve_next(1, 2, rnd_line());
        chk("i_after_d_drops", last_d[1], 0);
        random_rounds(1, 30);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical-memory cacheline port between the instruction cache and the data cache.
- Sits between the two L1 caches and the cacheline adaptor.
- Serializes line fills and write-backs, one transaction at a time, under a selectable grant policy.
- Latches the winner's command, then returns the response to the winner only.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, line address width.
- RR_EN, 1: 1 = round-robin on simultaneous requests; 0 = fixed dcache priority.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line-read request; held until i_resp.
- i_addr  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  one-cycle icache completion pulse.
- d_read  in  1  dcache line-read request.
- d_write  in  1  dcache line write-back request.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache write-back line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  one-cycle dcache completion pulse.
- mem_read  out  1  memory-side read command.
- mem_write  out  1  memory-side write command.
- mem_addr  out  ADDR_W  memory-side address.
- mem_wdata  out  LINE_W  memory-side write data.
- mem_rdata  in  LINE_W  memory-side read data.
- mem_resp  in  1  memory-side completion pulse.

Behaviour:
- Reset (rst_n low, any time, including mid-transaction):
  - State goes to IDLE.
  - All outputs 0.
  - Latched address/data registers cleared.
  - last_grant set to ICACHE, so the first tie under RR_EN=1 goes to dcache.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE:
  - Samples i_read and (d_read|d_write).
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted, RR_EN=1: grant the one not equal to last_grant. RR_EN=0: grant dcache.
  - On grant, latch the winner's address (and d_wdata and the read/write type for dcache). Update last_grant.
- SERVE_x:
  - mem_read or mem_write is driven from the latched registers, asserted from the cycle after the grant edge.
  - Held steady until mem_resp.
  - Requester-side address/data changes while in SERVE_x are ignored.
- On mem_resp in SERVE_x:
  - mem_read and mem_write drop at the next edge.
  - mem_rdata is captured into the winner's rdata register.
  - Move to RESP_x.
- RESP_x:
  - x_resp = 1 for exactly one cycle; x_rdata is valid in that cycle.
  - Return to IDLE at the next edge.
  - x_rdata keeps its value until the next capture for that requester.
  - The loser's resp stays 0 throughout.
- Latency:
  - Request at edge N → mem command from cycle N+1.
  - mem_resp at cycle M → x_resp at cycle M+1.
  - Arbiter back in IDLE at M+2.
  - Minimum 3-cycle overhead per transaction on top of memory latency.
- d_read and d_write both high: protocol error. Treat as write, flagged by assertion.
- A pending loser request stays pending and is granted in the IDLE cycle after the winner's RESP. No request is dropped.
- Starvation: under RR_EN=1, a continuously requesting cache waits at most one other transaction.
- mem_resp outside SERVE_x: ignored, with assertion.
- mem_read and mem_write are never both 1. mem_* outputs are never active in IDLE or RESP_x.

Decomposition:
- Package arbiter_types:
  - enum arb_state_t (IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D).
  - enum requester_t (ICACHE, DCACHE).
  - localparam defaults for LINE_W and ADDR_W.
- Sub-module rr_picker: combinational 2-way grant from requests, last_grant and RR_EN. Reused later for a multi-port L2.
- FSM and datapath registers in mem_arbiter.

Test Plan:
- i_read alone, i_addr=0x0000_0060; memory responds after 5 cycles with pattern A → mem_read 1 from cycle 1; mem_addr=0x60; i_resp one cycle after mem_resp with i_rdata=A; d_resp stays 0.
- d_write alone, d_addr=0x0000_1000, d_wdata=B → mem_write=1, mem_addr=0x1000, mem_wdata=B until mem_resp; d_resp pulses once.
- i_read and d_read both asserted out of reset, RR_EN=1 → dcache served first, icache immediately after. A second simultaneous pair is served icache first.
- Same as previous with RR_EN=0, both held continuously for 4 transactions → all 4 grants to dcache; icache is served only after dcache drops its request.
- d_addr changed mid-SERVE_D → mem_addr holds the originally latched value.
- rst_n pulled low while in SERVE_I waiting on memory → all outputs 0 immediately. After release: IDLE, no spurious i_resp, fresh request served normally.
